// File: rtl/vc_rr_arbiter_if.sv
// Handshake bundle between the per-class VC FIFOs, the arbiter
// and the link-side output FIFO.
interface vc_rr_arbiter_if #(
  parameter int LINE_SIZE = 12
);
  logic [3:0]             state;
  logic [3:0]             empty;
  logic [4*LINE_SIZE-1:0] fifo_data;
  logic                   almost_full;
  logic [3:0]             pop;
  logic                   push;
  logic [LINE_SIZE-1:0]   data_out;
  logic [1:0]             grant_id;

  modport master (
    output state,
    output empty,
    output fifo_data,
    output almost_full,
    input  pop,
    input  push,
    input  data_out,
    input  grant_id
  );

  modport slave (
    input  state,
    input  empty,
    input  fifo_data,
    input  almost_full,
    output pop,
    output push,
    output data_out,
    output grant_id
  );
endinterface

// File: rtl/vc_rr_arbiter.sv
// Quantum round-robin arbiter: drains four VC FIFOs into one
// output FIFO, one word per cycle while the link is ACTIVE.
module vc_rr_arbiter #(
  parameter int LINE_SIZE = 12,
  parameter int QUANTUM   = 2
) (
  input  logic           clk,
  input  logic           reset_L,
  vc_rr_arbiter_if.slave bus
);
  localparam logic [3:0] ST_ACTIVE = 4'b1000;
  localparam int         CW        = $clog2(QUANTUM + 1);
  localparam logic [CW-1:0] Q_LAST = CW'(QUANTUM);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [LINE_SIZE-1:0] word [4];

  logic [1:0]    ptr;
  logic [1:0]    holder;
  logic          hvld;
  logic [CW-1:0] cnt;

  logic [1:0]    rr_g;
  logic          rr_hit;
  logic [1:0]    idx;
  logic          hold_ok;
  logic [1:0]    g;
  logic          have_g;
  logic          active;
  logic          enable;
  logic          fire;
  logic [CW-1:0] cnt_nxt;
  logic          expire;
  logic          holder_dry;

  logic                 push_q;
  logic [LINE_SIZE-1:0] data_q;
  logic [1:0]           gid_q;

  for (genvar i = 0; i < 4; i++) begin : g_word
    assign word[i] = bus.fifo_data[i*LINE_SIZE +: LINE_SIZE];
  end

  // Walk from the farthest offset down so the entry nearest ptr wins.
  always_comb begin
    rr_hit = 1'b0;
    rr_g   = ptr;
    idx    = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (!bus.empty[idx]) begin
        rr_hit = 1'b1;
        rr_g   = idx;
      end
    end
  end

  always_comb begin
    hold_ok    = hvld && (cnt < Q_LAST) && !bus.empty[holder];
    g          = hold_ok ? holder : rr_g;
    have_g     = hold_ok || rr_hit;
    active     = (bus.state == ST_ACTIVE);
    enable     = active && !bus.almost_full && reset_L;
    fire       = enable && have_g;
    holder_dry = hvld && bus.empty[holder];
    cnt_nxt    = (hvld && g == holder) ? cnt + ONE : ONE;
    expire     = (cnt_nxt == Q_LAST);
  end

  always_comb begin
    bus.pop = 4'b0000;
    if (fire) begin
      unique case (1'b1)
        (g == 2'd0): bus.pop = 4'b0001;
        (g == 2'd1): bus.pop = 4'b0010;
        (g == 2'd2): bus.pop = 4'b0100;
        (g == 2'd3): bus.pop = 4'b1000;
        default:     bus.pop = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      push_q <= 1'b0;
      data_q <= '0;
      gid_q  <= '0;
    end else begin
      push_q <= fire;
      if (fire) begin
        data_q <= word[g];
        gid_q  <= g;
      end
    end
  end

  // Expiry rotates past the granted channel and takes precedence
  // over the dry-holder skip.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr    <= '0;
      holder <= '0;
      hvld   <= 1'b0;
      cnt    <= '0;
    end else if (!active) begin
      hvld <= 1'b0;
      cnt  <= '0;
    end else if (fire) begin
      if (expire) begin
        ptr  <= g + 2'd1;
        hvld <= 1'b0;
        cnt  <= '0;
      end else begin
        if (holder_dry) begin
          ptr <= holder + 2'd1;
        end
        holder <= g;
        hvld   <= 1'b1;
        cnt    <= cnt_nxt;
      end
    end else if (enable && holder_dry) begin
      ptr  <= holder + 2'd1;
      hvld <= 1'b0;
      cnt  <= '0;
    end
  end

  assign bus.push     = push_q;
  assign bus.data_out = data_q;
  assign bus.grant_id = gid_q;
endmodule
